// File: rtl/paddle_move_ctrl.sv
// ============================================================================
// paddle_move_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Converts the raw left/right push-buttons into paced, single-cycle
//   moveLeft/moveRight pulses for the paddle datapath. The paddle moves at
//   most once per video frame instead of once per clock. The block:
//     - synchronises each button with two flops and debounces it,
//     - resolves conflicting presses (both held = no motion),
//     - suppresses moves at the playfield limits using xPos from the paddle,
//     - gates all motion with the game-enable input.
//
// Optional feature (compile-time macro PADDLE_ACCEL_EN):
//   When defined, a fresh hold starts in a slow phase. A pulse fires only
//   on every SLOW_PERIOD-th frameTick, and the first frameTick after entry
//   always fires. Once ACCEL_FRAMES frames have been held, every frameTick
//   fires. When undefined, every frameTick in a hold state pulses and no
//   slow-phase logic is built.
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   btnLeft    in   1   raw asynchronous left button, active-high
//   btnRight   in   1   raw asynchronous right button, active-high
//   frameTick  in   1   one-cycle pulse per video frame
//   enable     in   1   game running; low freezes the paddle
//   xPos       in  10   current paddle x position (sampled on frameTick)
//   moveLeft   out  1   registered one-cycle move-left pulse
//   moveRight  out  1   registered one-cycle move-right pulse
//   ctrlState  out  2   00 IDLE, 01 HOLD_L, 10 HOLD_R (11 unused)
//   atEdge     out  1   registered; high when the last frameTick in a hold
//                       state had its pulse suppressed by a limit
// ============================================================================
module paddle_move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LEFT_LIMIT      = 4,
    parameter int RIGHT_LIMIT     = 500,
    parameter int SLOW_PERIOD     = 2,
    parameter int ACCEL_FRAMES    = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       frameTick,
    input  logic       enable,
    input  logic [9:0] xPos,
    output logic       moveLeft,
    output logic       moveRight,
    output logic [1:0] ctrlState,
    output logic       atEdge
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int              HF_W    = ($clog2(ACCEL_FRAMES + 1) < 1) ? 1
                                          : $clog2(ACCEL_FRAMES + 1);
    localparam logic [HF_W-1:0] HF_MAX  = HF_W'(ACCEL_FRAMES);

    localparam logic [9:0]      L_LIMIT = 10'(LEFT_LIMIT);
    localparam logic [9:0]      R_LIMIT = 10'(RIGHT_LIMIT);

    // Elaboration-time sanity check on the pacing parameter.
    generate
        if (SLOW_PERIOD < 1) begin : g_bad_slow_period
            $error("paddle_move_ctrl: SLOW_PERIOD must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Input path: 2-flop synchroniser + debounce, one lane per button
    // (lane 0 = left, lane 1 = right).
    // ------------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    assign w_btn_raw = {btnRight, btnLeft};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            r_meta;
            logic            r_sync;
            logic            r_db;
            logic [DB_W-1:0] r_db_cnt;

            // The counter only runs while the synchronised value disagrees
            // with the debounced level, so any glitch back to agreement
            // restarts the stability window from zero.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_meta   <= 1'b0;
                    r_sync   <= 1'b0;
                    r_db     <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_meta <= w_btn_raw[gi];
                    r_sync <= r_meta;
                    if (r_sync == r_db) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_db     <= ~r_db;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    logic w_db_l;
    logic w_db_r;
    assign w_db_l = g_btn[0].r_db;
    assign w_db_r = g_btn[1].r_db;

    // ------------------------------------------------------------------------
    // Hold-direction FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HOLD_L = 2'b01,
        ST_HOLD_R = 2'b10
    } state_t;

    state_t          r_state;
    logic            r_move_l;
    logic            r_move_r;
    logic            r_at_edge;
    logic [HF_W-1:0] r_hold_frames;

    logic w_go_l;
    logic w_go_r;
    logic w_leave_l;
    logic w_leave_r;
    logic w_in_hold;
    logic w_pace_due;

    assign w_go_l    = w_db_l & ~w_db_r & enable;
    assign w_go_r    = w_db_r & ~w_db_l & enable;
    assign w_leave_l = ~w_db_l | w_db_r | ~enable;
    assign w_leave_r = ~w_db_r | w_db_l | ~enable;
    assign w_in_hold = (r_state == ST_HOLD_L) || (r_state == ST_HOLD_R);

`ifdef PADDLE_ACCEL_EN
    localparam int              SC_W    = (SLOW_PERIOD > 1) ? $clog2(SLOW_PERIOD) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SLOW_PERIOD - 1);

    logic [SC_W-1:0] r_slow_cnt;

    // Slow phase: fire when the mod-SLOW_PERIOD phase is zero. It is zero at
    // entry, so the first frameTick of a hold always fires.
    assign w_pace_due = (r_hold_frames == HF_MAX) || (r_slow_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slow_cnt <= '0;
        end else if ((r_state == ST_IDLE) && (w_go_l || w_go_r)) begin
            r_slow_cnt <= '0;
        end else if (frameTick && w_in_hold) begin
            r_slow_cnt <= (r_slow_cnt == SC_LAST) ? '0 : r_slow_cnt + 1'b1;
        end
    end
`else
    assign w_pace_due = 1'b1;
`endif

    // Pulse decisions use the registered state on the frameTick cycle, so a
    // frameTick that coincides with IDLE->HOLD entry never pulses. Dropping
    // enable on a frameTick also blocks the pulse, because the decision
    // requires enable in that same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_move_l      <= 1'b0;
            r_move_r      <= 1'b0;
            r_at_edge     <= 1'b0;
            r_hold_frames <= '0;
        end else begin
            r_move_l <= 1'b0;
            r_move_r <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_go_l) begin
                        r_state       <= ST_HOLD_L;
                        r_hold_frames <= '0;
                    end else if (w_go_r) begin
                        r_state       <= ST_HOLD_R;
                        r_hold_frames <= '0;
                    end
                end
                ST_HOLD_L: begin
                    if (w_leave_l) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD_R: begin
                    if (w_leave_r) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (frameTick) begin
                if (!w_in_hold) begin
                    r_at_edge <= 1'b0;
                end else begin
                    if (r_hold_frames != HF_MAX) begin
                        r_hold_frames <= r_hold_frames + 1'b1;
                    end

                    if (enable && w_pace_due) begin
                        if (r_state == ST_HOLD_L) begin
                            if (xPos > L_LIMIT) begin
                                r_move_l  <= 1'b1;
                                r_at_edge <= 1'b0;
                            end else begin
                                r_at_edge <= 1'b1;
                            end
                        end else begin
                            if (xPos < R_LIMIT) begin
                                r_move_r  <= 1'b1;
                                r_at_edge <= 1'b0;
                            end else begin
                                r_at_edge <= 1'b1;
                            end
                        end
                    end else begin
                        // No pulse was due, so nothing was held back by a limit.
                        r_at_edge <= 1'b0;
                    end
                end
            end
        end
    end

    assign moveLeft  = r_move_l;
    assign moveRight = r_move_r;
    assign ctrlState = r_state;
    assign atEdge    = r_at_edge;

endmodule

// File: tb/tb_paddle_move_ctrl.sv
module tb_paddle_move_ctrl;

    localparam int DEB = 4;
    localparam int LL  = 4;
    localparam int RL  = 500;
    localparam int SP  = 2;
    localparam int AF  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btnLeft;
    logic       btnRight;
    logic       frameTick;
    logic       enable;
    logic [9:0] xPos;
    logic       moveLeft;
    logic       moveRight;
    logic [1:0] ctrlState;
    logic       atEdge;

    paddle_move_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .LEFT_LIMIT     (LL),
        .RIGHT_LIMIT    (RL),
        .SLOW_PERIOD    (SP),
        .ACCEL_FRAMES   (AF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btnLeft  (btnLeft),
        .btnRight (btnRight),
        .frameTick(frameTick),
        .enable   (enable),
        .xPos     (xPos),
        .moveLeft (moveLeft),
        .moveRight(moveRight),
        .ctrlState(ctrlState),
        .atEdge   (atEdge)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int hold_n   = 0;

    // Expected {moveLeft, moveRight, atEdge} for each frameTick, pushed when
    // the tick is driven and popped the cycle the DUT must answer.
    logic [2:0] exp_q[$];
    logic       tick_s = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    endtask

    always @(posedge clk) tick_s <= frameTick;

    always @(negedge clk) begin
        logic [2:0] e;
        chk("never_both", {31'd0, moveLeft & moveRight}, 32'd0);
        if (tick_s) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("tick_moves", {30'd0, moveLeft, moveRight}, {30'd0, e[2:1]});
                chk("tick_atedge", {31'd0, atEdge}, {31'd0, e[0]});
                $display("tick: exp L=%0b R=%0b E=%0b got L=%0b R=%0b E=%0b st=%0d",
                         e[2], e[1], e[0], moveLeft, moveRight, atEdge, ctrlState);
            end
        end else begin
            chk("no_stray_pulse", {30'd0, moveLeft, moveRight}, 32'd0);
        end
    end

    // Expected pacing for the n-th frameTick (1-based) of a hold.
    function automatic bit pace(input int n);
`ifdef PADDLE_ACCEL_EN
        if (n - 1 >= AF) return 1'b1;
        return ((n - 1) % SP) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick(input logic [2:0] e);
        exp_q.push_back(e);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic hold_tick(input bit left);
        logic [2:0] e;
        hold_n++;
        if (!pace(hold_n))   e = 3'b000;
        else if (left)       e = (xPos > 10'(LL)) ? 3'b100 : 3'b001;
        else                 e = (xPos < 10'(RL)) ? 3'b010 : 3'b001;
        tick(e);
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag, output int n);
        n = 0;
        while (ctrlState !== s && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {30'd0, ctrlState}, {30'd0, s});
        $display("wait %s: state=%0d after %0d cycles", tag, ctrlState, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; btnLeft = 1'b0; btnRight = 1'b0;
        frameTick = 1'b0; enable = 1'b1; xPos = 10'd100;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {28'd0, moveLeft, moveRight, atEdge, 1'b0}, 32'd0);
        chk("reset_state", {30'd0, ctrlState}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Short glitch: 3 cycles high must not pass the debouncer.
        btnLeft = 1'b1;
        repeat (3) @(negedge clk);
        btnLeft = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("glitch_idle", {30'd0, ctrlState}, 32'd0);
        end

        // Held press: HOLD_L about 2 sync + 4 debounce cycles later.
        btnLeft = 1'b1;
        wait_state(2'b01, "press_left", n);
        chk("debounce_latency_ok", {31'd0, (n >= 5 && n <= 8)}, 32'd1);
        hold_n = 0;

        for (int i = 0; i < 5; i++) hold_tick(1'b1);
        xPos = 10'd4;
        hold_tick(1'b1);
        chk("left_limit_edge", {31'd0, atEdge}, {31'd0, pace(hold_n)});
        xPos = 10'd5;
        hold_tick(1'b1);

        btnLeft = 1'b0;
        wait_state(2'b00, "release_left", n);
        tick(3'b000);

        // Right limit.
        xPos = 10'd500;
        btnRight = 1'b1;
        wait_state(2'b10, "press_right", n);
        hold_n = 0;
        for (int i = 0; i < 3; i++) hold_tick(1'b0);
        xPos = 10'd499;
        hold_tick(1'b0);

        // Both held: IDLE, no motion; release left resumes right.
        btnLeft = 1'b1;
        wait_state(2'b00, "both_held", n);
        for (int i = 0; i < 10; i++) tick(3'b000);
        btnLeft = 1'b0;
        wait_state(2'b10, "release_left_to_right", n);
        hold_n = 0;
        hold_tick(1'b0);

        // enable falls on the same cycle as frameTick.
        exp_q.push_back(3'b000);
        frameTick = 1'b1; enable = 1'b0;
        @(negedge clk);
        frameTick = 1'b0;
        chk("enable_drop_state", {30'd0, ctrlState}, 32'd0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        wait_state(2'b10, "enable_resume", n);
        btnRight = 1'b0;
        wait_state(2'b00, "release_right", n);

        // Long hold left: 8 frames (exercises pacing when enabled).
        xPos = 10'd100;
        btnLeft = 1'b1;
        wait_state(2'b01, "press_left_long", n);
        hold_n = 0;
        for (int i = 0; i < 8; i++) hold_tick(1'b1);

        // Reset together with a frameTick that would have pulsed.
        exp_q.push_back(3'b000);
        frameTick = 1'b1; reset = 1'b1;
        @(negedge clk);
        frameTick = 1'b0; reset = 1'b0;
        chk("reset_mid_hold_state", {30'd0, ctrlState}, 32'd0);
        btnLeft = 1'b0;
        repeat (4) @(negedge clk);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
